// File: rtl/vga_renderer.sv
// vga_renderer: 640x480@60 timing generator with a bird sprite, N_PIPES pipe
// obstacles and an optional blue background. Object coordinates are copied to
// shadow registers once per frame at vertical blank, so the picture never tears.
// Sync and colour travel through a three-stage pipeline that advances on the
// pixel enable, so both leave the pins on the same cycle.
module vga_renderer #(
    parameter int CLK_DIV   = 2,
    parameter int N_PIPES   = 4,
    parameter int PIPE_W    = 80,
    parameter int GAP_H     = 100,
    parameter int BIRD_HALF = 10,
    parameter int BG_EN     = 0
) (
    input  logic                  ClkPort,
    input  logic                  reset,
    input  logic [9:0]            BirdX,
    input  logic [9:0]            BirdY,
    input  logic [10*N_PIPES-1:0] PipeX,
    input  logic [10*N_PIPES-1:0] PipeGapY,
    output logic                  vga_h_sync,
    output logic                  vga_v_sync,
    output logic                  vga_r,
    output logic                  vga_g,
    output logic                  vga_b,
    output logic                  frame_tick
);
    localparam int DIV_W = (CLK_DIV > 0) ? CLK_DIV : 1;
    localparam logic signed [11:0] BIRD_HALF_S = 12'(BIRD_HALF);
    localparam logic signed [11:0] PIPE_W_M1   = 12'(PIPE_W - 1);
    localparam logic signed [11:0] GAP_H_M1    = 12'(GAP_H - 1);
    localparam logic               BG_BIT      = (BG_EN != 0);

    logic [DIV_W-1:0]      div_q, div_d;
    logic                  pe, latch;
    logic [9:0]            hc_q, hc_d, vc_q, vc_d;
    logic [9:0]            bird_x_q, bird_x_d, bird_y_q, bird_y_d;
    logic [10*N_PIPES-1:0] pipe_x_q, pipe_x_d, pipe_gap_q, pipe_gap_d;
    logic                  obj_valid_q, obj_valid_d, frame_tick_q, frame_tick_d;
    logic [9:0]            s1_hc_q, s1_hc_d, s1_vc_q, s1_vc_d;
    logic                  s1_vis_q, s1_vis_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
    logic                  bird_hit, pipe_hit;
    logic                  s2_bird_q, s2_bird_d, s2_pipe_q, s2_pipe_d;
    logic                  s2_vis_q, s2_vis_d, s2_hs_q, s2_hs_d, s2_vs_q, s2_vs_d;
    logic                  s3_r_q, s3_r_d, s3_g_q, s3_g_d, s3_b_q, s3_b_d;
    logic                  s3_hs_q, s3_hs_d, s3_vs_q, s3_vs_d;

    // Pixel enable: fires when the free-running divider is all-ones (always, when undivided).
    always_comb begin
        div_d = div_q + DIV_W'(1);
        pe    = (CLK_DIV == 0) ? 1'b1 : (div_q == {DIV_W{1'b1}});
    end

    // Horizontal 0..799 and vertical 0..524 counters, stepping once per pixel.
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (pe) begin
            if (hc_q == 10'd799) begin
                hc_d = 10'd0;
                vc_d = (vc_q == 10'd524) ? 10'd0 : vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    // Shadow latch at the start of vertical blank; only this copy is ever drawn.
    always_comb begin
        latch        = pe && (hc_q == 10'd0) && (vc_q == 10'd480);
        bird_x_d     = latch ? BirdX    : bird_x_q;
        bird_y_d     = latch ? BirdY    : bird_y_q;
        pipe_x_d     = latch ? PipeX    : pipe_x_q;
        pipe_gap_d   = latch ? PipeGapY : pipe_gap_q;
        obj_valid_d  = obj_valid_q | latch;
        frame_tick_d = latch;
    end

    // Stage 1: capture the counters with their raw visible and sync flags.
    always_comb begin
        s1_hc_d  = s1_hc_q;
        s1_vc_d  = s1_vc_q;
        s1_vis_d = s1_vis_q;
        s1_hs_d  = s1_hs_q;
        s1_vs_d  = s1_vs_q;
        if (pe) begin
            s1_hc_d  = hc_q;
            s1_vc_d  = vc_q;
            s1_vis_d = (hc_q < 10'd640) && (vc_q < 10'd480);
            s1_hs_d  = !((hc_q >= 10'd656) && (hc_q <= 10'd751));
            s1_vs_d  = !((vc_q >= 10'd490) && (vc_q <= 10'd491));
        end
    end

    // Object hit tests in 12-bit signed space so off-screen objects clip instead of wrapping.
    always_comb begin
        logic signed [11:0] hc_s, vc_s, bx, by, px, gy;
        hc_s     = $signed({2'b00, s1_hc_q});
        vc_s     = $signed({2'b00, s1_vc_q});
        bx       = $signed({{2{bird_x_q[9]}}, bird_x_q});
        by       = $signed({{2{bird_y_q[9]}}, bird_y_q});
        px       = '0;
        gy       = '0;
        bird_hit = obj_valid_q &&
                   (hc_s >= bx - BIRD_HALF_S) && (hc_s <= bx + BIRD_HALF_S) &&
                   (vc_s >= by - BIRD_HALF_S) && (vc_s <= by + BIRD_HALF_S);
        pipe_hit = 1'b0;
        for (int i = 0; i < N_PIPES; i++) begin
            px = $signed({{2{pipe_x_q[10*i+9]}}, pipe_x_q[10*i +: 10]});
            gy = $signed({{2{pipe_gap_q[10*i+9]}}, pipe_gap_q[10*i +: 10]});
            if (obj_valid_q && (hc_s >= px) && (hc_s <= px + PIPE_W_M1) &&
                !((vc_s >= gy) && (vc_s <= gy + GAP_H_M1))) begin
                pipe_hit = 1'b1;
            end
        end
    end

    // Stage 2: register hit flags and carry visible/sync alongside them.
    always_comb begin
        s2_bird_d = s2_bird_q;
        s2_pipe_d = s2_pipe_q;
        s2_vis_d  = s2_vis_q;
        s2_hs_d   = s2_hs_q;
        s2_vs_d   = s2_vs_q;
        if (pe) begin
            s2_bird_d = bird_hit;
            s2_pipe_d = pipe_hit;
            s2_vis_d  = s1_vis_q;
            s2_hs_d   = s1_hs_q;
            s2_vs_d   = s1_vs_q;
        end
    end

    // Stage 3: resolve colour by priority bird > pipe > background, blank outside the visible area.
    always_comb begin
        s3_r_d  = s3_r_q;
        s3_g_d  = s3_g_q;
        s3_b_d  = s3_b_q;
        s3_hs_d = s3_hs_q;
        s3_vs_d = s3_vs_q;
        if (pe) begin
            s3_r_d  = s2_vis_q && s2_bird_q;
            s3_g_d  = s2_vis_q && !s2_bird_q && s2_pipe_q;
            s3_b_d  = s2_vis_q && !s2_bird_q && !s2_pipe_q && BG_BIT;
            s3_hs_d = s2_hs_q;
            s3_vs_d = s2_vs_q;
        end
    end

    // All state registers; reset idles the pipeline with syncs high and colour off.
    always_ff @(posedge ClkPort or negedge reset) begin
        if (!reset) begin
            div_q        <= '0;
            hc_q         <= '0;
            vc_q         <= '0;
            bird_x_q     <= '0;
            bird_y_q     <= '0;
            pipe_x_q     <= '0;
            pipe_gap_q   <= '0;
            obj_valid_q  <= 1'b0;
            frame_tick_q <= 1'b0;
            s1_hc_q      <= '0;
            s1_vc_q      <= '0;
            s1_vis_q     <= 1'b0;
            s1_hs_q      <= 1'b1;
            s1_vs_q      <= 1'b1;
            s2_bird_q    <= 1'b0;
            s2_pipe_q    <= 1'b0;
            s2_vis_q     <= 1'b0;
            s2_hs_q      <= 1'b1;
            s2_vs_q      <= 1'b1;
            s3_r_q       <= 1'b0;
            s3_g_q       <= 1'b0;
            s3_b_q       <= 1'b0;
            s3_hs_q      <= 1'b1;
            s3_vs_q      <= 1'b1;
        end else begin
            div_q        <= div_d;
            hc_q         <= hc_d;
            vc_q         <= vc_d;
            bird_x_q     <= bird_x_d;
            bird_y_q     <= bird_y_d;
            pipe_x_q     <= pipe_x_d;
            pipe_gap_q   <= pipe_gap_d;
            obj_valid_q  <= obj_valid_d;
            frame_tick_q <= frame_tick_d;
            s1_hc_q      <= s1_hc_d;
            s1_vc_q      <= s1_vc_d;
            s1_vis_q     <= s1_vis_d;
            s1_hs_q      <= s1_hs_d;
            s1_vs_q      <= s1_vs_d;
            s2_bird_q    <= s2_bird_d;
            s2_pipe_q    <= s2_pipe_d;
            s2_vis_q     <= s2_vis_d;
            s2_hs_q      <= s2_hs_d;
            s2_vs_q      <= s2_vs_d;
            s3_r_q       <= s3_r_d;
            s3_g_q       <= s3_g_d;
            s3_b_q       <= s3_b_d;
            s3_hs_q      <= s3_hs_d;
            s3_vs_q      <= s3_vs_d;
        end
    end

    assign vga_h_sync = s3_hs_q;
    assign vga_v_sync = s3_vs_q;
    assign vga_r      = s3_r_q;
    assign vga_g      = s3_g_q;
    assign vga_b      = s3_b_q;
    assign frame_tick = frame_tick_q;

endmodule
